// File: rtl/execute_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, registered {Z,V,N} flags and,
// when EXEC_MUL_EN is defined, an iterative signed shift-add multiply with a stall handshake.
module execute_stage_mc #(
    parameter int                DATA_W      = 16,
    parameter logic [DATA_W-1:0] DEFAULT_OUT = {4'h0, {(DATA_W-4){1'b1}}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [4:0]        opcode,
    input  logic [1:0]        aluOp,
    input  logic              aluSrc,
    input  logic [DATA_W-1:0] read_data_1,
    input  logic [DATA_W-1:0] read_data_2,
    input  logic [DATA_W-1:0] imm,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] value_to_write,
    output logic [2:0]        flags,
    output logic              stall,
    output logic              mul_done
);
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [4:0] OP_ADDI  = 5'b00100;
    localparam logic [4:0] OP_SUBI  = 5'b00101;
    localparam logic [4:0] OP_ARITH = 5'b00110;
    localparam logic [4:0] OP_LOGIC = 5'b00111;
    localparam logic [4:0] OP_SLL   = 5'b01000;
    localparam logic [4:0] OP_SRL   = 5'b01001;
    localparam logic [4:0] OP_SRA   = 5'b01010;
    localparam logic [4:0] OP_MOV   = 5'b01011;
    localparam logic [4:0] OP_ST    = 5'b01100;
    localparam logic [4:0] OP_LD    = 5'b01101;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

    typedef enum logic [1:0] {FL_HOLD, FL_ARITH, FL_LOGIC} fl_cls_e;

    logic [DATA_W-1:0] op_a, op_bf, op_b;
    logic [DATA_W-1:0] add_rhs, add_eff, add_sum;
    logic              add_is_sub, add_v;
    logic [DATA_W-1:0] alu_res;
    logic [SH_W-1:0]   shamt;
    fl_cls_e           fl_cls;
    flags_t            flags_q;
    logic              single_we;
    logic              mul_fl_we;
    flags_t            mul_fl;

    // Select 11 deliberately falls through to the register value
    always_comb begin
        case (fwd_a)
            2'b01:   op_a = exmem_data;
            2'b10:   op_a = memwb_data;
            default: op_a = read_data_1;
        endcase
        case (fwd_b)
            2'b01:   op_bf = exmem_data;
            2'b10:   op_bf = memwb_data;
            default: op_bf = read_data_2;
        endcase
        op_b = aluSrc ? imm : op_bf;
    end

    // One shared adder; subtraction is A + ~rhs + 1 so V uses the inverted operand
    always_comb begin
        add_rhs    = (opcode == OP_ARITH) ? op_b : imm;
        add_is_sub = (opcode == OP_SUBI) || ((opcode == OP_ARITH) && (aluOp == 2'b01));
        add_eff    = add_is_sub ? ~add_rhs : add_rhs;
        add_sum    = op_a + add_eff + {{(DATA_W-1){1'b0}}, add_is_sub};
        add_v      = (op_a[DATA_W-1] == add_eff[DATA_W-1]) &&
                     (add_sum[DATA_W-1] != op_a[DATA_W-1]);
    end

    assign shamt = imm[SH_W-1:0];

    always_comb begin
        alu_res = DEFAULT_OUT;
        fl_cls  = FL_HOLD;
        case (opcode)
            OP_ADDI, OP_SUBI: begin
                alu_res = add_sum;
                fl_cls  = FL_ARITH;
            end
            OP_ARITH: begin
                if (!aluOp[1]) begin
                    alu_res = add_sum;
                    fl_cls  = FL_ARITH;
                end
            end
            OP_LOGIC: begin
                fl_cls = FL_LOGIC;
                case (aluOp)
                    2'b00:   alu_res = op_a & op_b;
                    2'b01:   alu_res = op_a | op_b;
                    2'b10:   alu_res = op_a ^ op_b;
                    default: alu_res = ~op_a;
                endcase
            end
            OP_SLL: begin
                alu_res = op_a << shamt;
                fl_cls  = FL_LOGIC;
            end
            OP_SRL: begin
                alu_res = op_a >> shamt;
                fl_cls  = FL_LOGIC;
            end
            OP_SRA: begin
                alu_res = DATA_W'($signed(op_a) >>> shamt);
                fl_cls  = FL_LOGIC;
            end
            OP_MOV:       alu_res = op_a;
            OP_ST, OP_LD: alu_res = add_sum;
            default: begin
                if (opcode[4:3] == 2'b10)
                    alu_res = imm;
            end
        endcase
    end

    assign value_to_write = (opcode == OP_ST) ? op_bf : '0;

`ifdef EXEC_MUL_EN
    localparam logic [4:0] OP_MUL = 5'b00010;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mul_state_e;

    mul_state_e          state, state_nxt;
    logic [SH_W-1:0]     cnt;
    logic [2*DATA_W-1:0] acc, mcand;
    logic [DATA_W-1:0]   mplier;
    logic [DATA_W-1:0]   prod_lo, prod_hi;
    logic                mul_issue;

    assign mul_issue = (state == S_IDLE) && in_valid && (opcode == OP_MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (mul_issue) state_nxt = S_RUN;
            S_RUN:   if (cnt == '0) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        stall     = mul_issue || (state == S_RUN);
        mul_done  = (state == S_DONE);
        single_we = in_valid && (state == S_IDLE);
        mul_fl_we = (state == S_DONE);
        alu_out   = alu_res;
        if (state == S_DONE)      alu_out = prod_lo;
        else if (state != S_IDLE) alu_out = DEFAULT_OUT;
    end

    // Signed shift-add: multiplier LSB first; the sign bit (last step, cnt==0) carries
    // negative weight, so it is subtracted instead of added.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (mul_issue) begin
            cnt    <= SH_W'(DATA_W-1);
            acc    <= '0;
            mcand  <= {{DATA_W{op_a[DATA_W-1]}}, op_a};
            mplier <= op_b;
        end else if (state == S_RUN) begin
            if (mplier[0])
                acc <= (cnt == '0) ? acc - mcand : acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    assign prod_lo  = acc[DATA_W-1:0];
    assign prod_hi  = acc[2*DATA_W-1:DATA_W];
    assign mul_fl.z = (prod_lo == '0);
    assign mul_fl.v = (prod_hi != {DATA_W{prod_lo[DATA_W-1]}});
    assign mul_fl.n = prod_lo[DATA_W-1];
`else
    assign stall     = 1'b0;
    assign mul_done  = 1'b0;
    assign single_we = in_valid;
    assign mul_fl_we = 1'b0;
    assign mul_fl    = '0;
    assign alu_out   = alu_res;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (mul_fl_we) begin
            flags_q <= mul_fl;
        end else if (single_we) begin
            case (fl_cls)
                FL_ARITH: flags_q <= '{z: (alu_res == '0), v: add_v, n: alu_res[DATA_W-1]};
                FL_LOGIC: flags_q <= '{z: (alu_res == '0), v: 1'b0, n: 1'b0};
                default:  flags_q <= flags_q;
            endcase
        end
    end

    assign flags = flags_q;

endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed-vector bench for execute_stage_mc at DATA_W=16; MUL vectors run only when
// EXEC_MUL_EN is defined, otherwise opcode 00010 is checked to behave as NOP.
module tb_execute_stage_mc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  opcode;
    logic [1:0]  aluOp;
    logic        aluSrc;
    logic [15:0] read_data_1, read_data_2, imm, exmem_data, memwb_data;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] alu_out, value_to_write;
    logic [2:0]  flags;
    logic        stall, mul_done;

    int n_chk  = 0;
    int n_pass = 0;

    execute_stage_mc #(.DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode), .aluOp(aluOp),
        .aluSrc(aluSrc), .read_data_1(read_data_1), .read_data_2(read_data_2), .imm(imm),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .exmem_data(exmem_data), .memwb_data(memwb_data),
        .alu_out(alu_out), .value_to_write(value_to_write), .flags(flags),
        .stall(stall), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [1:0] ao, input logic src,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] im);
        in_valid    = 1'b1;
        opcode      = op;
        aluOp       = ao;
        aluSrc      = src;
        read_data_1 = a;
        read_data_2 = b;
        imm         = im;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
    endtask

    // Drive one op, check combinational result mid-cycle, then flags after the edge
    task automatic run_op(input string tag, input logic [4:0] op, input logic [1:0] ao,
                          input logic src, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] im, input logic [15:0] exp_out,
                          input logic [2:0] exp_fl);
        drive(op, ao, src, a, b, im);
        @(negedge clk);
        chk({tag, ".out"}, 32'(alu_out), 32'(exp_out));
        step();
        chk({tag, ".flags"}, 32'(flags), 32'(exp_fl));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(5'b00000, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0);
        exmem_data = 16'h0;
        memwb_data = 16'h0;
        #2;
        chk("rst.flags", 32'(flags), 32'h0);
        chk("rst.stall", 32'(stall), 32'h0);
        chk("rst.done", 32'(mul_done), 32'h0);
        chk("rst.nop_out", 32'(alu_out), 32'h0FFF);
        step();
        rst_n = 1'b1;
        step();

        // ADD then SUB; vtw must be zero for non-store ops
        drive(5'b00110, 2'b00, 1'b0, 16'h1234, 16'h1111, 16'h0);
        @(negedge clk);
        chk("add.vtw", 32'(value_to_write), 32'h0);
        step();
        run_op("add", 5'b00110, 2'b00, 1'b0, 16'h1234, 16'h1111, 16'h0, 16'h2345, 3'b000);
        run_op("sub", 5'b00110, 2'b01, 1'b0, 16'h0303, 16'h0304, 16'h0, 16'hFFFF, 3'b001);

        // ST: store data comes from forwarded B, never imm; flags held
        drive(5'b01100, 2'b00, 1'b1, 16'h0100, 16'h7777, 16'h0020);
        fwd_b = 2'b01;
        exmem_data = 16'hBEEF;
        @(negedge clk);
        chk("st.out", 32'(alu_out), 32'h0120);
        chk("st.vtw", 32'(value_to_write), 32'hBEEF);
        step();
        chk("st.flags", 32'(flags), 32'b001);

        run_op("addi", 5'b00100, 2'b00, 1'b0, 16'h7FFF, 16'h0, 16'h0001, 16'h8000, 3'b011);
        run_op("and", 5'b00111, 2'b00, 1'b0, 16'hF0F0, 16'hFF00, 16'h0, 16'hF000, 3'b000);

        // Forwarded SUB: A from EX/MEM, B from MEM/WB
        drive(5'b00110, 2'b01, 1'b0, 16'hAAAA, 16'h5555, 16'h0);
        fwd_a = 2'b01; fwd_b = 2'b10;
        exmem_data = 16'h0010; memwb_data = 16'h0005;
        @(negedge clk);
        chk("fwd.sub", 32'(alu_out), 32'h000B);
        step();
        // Select 11 reads the register file
        drive(5'b00110, 2'b00, 1'b0, 16'h0040, 16'h0002, 16'h0);
        fwd_a = 2'b11; fwd_b = 2'b11;
        @(negedge clk);
        chk("fwd11.add", 32'(alu_out), 32'h0042);
        step();

        // Shift amount uses only imm[3:0]
        run_op("sll", 5'b01000, 2'b00, 1'b0, 16'h8001, 16'h0, 16'h0014, 16'h0010, 3'b000);
        run_op("srl", 5'b01001, 2'b00, 1'b0, 16'h8001, 16'h0, 16'h0014, 16'h0800, 3'b000);
        run_op("sra", 5'b01010, 2'b00, 1'b0, 16'h8001, 16'h0, 16'h0014, 16'hF800, 3'b000);
        run_op("or", 5'b00111, 2'b01, 1'b0, 16'h00F0, 16'h0F00, 16'h0, 16'h0FF0, 3'b000);
        run_op("xor", 5'b00111, 2'b10, 1'b1, 16'hFFFF, 16'h0, 16'h0F0F, 16'hF0F0, 3'b000);
        run_op("subi", 5'b00101, 2'b00, 1'b0, 16'h8000, 16'h0, 16'h0001, 16'h7FFF, 3'b010);
        run_op("not", 5'b00111, 2'b11, 1'b0, 16'hFFFF, 16'h0, 16'h0, 16'h0000, 3'b100);
        run_op("hash", 5'b11100, 2'b00, 1'b0, 16'h1234, 16'h0, 16'h0, 16'h0FFF, 3'b100);
        run_op("nop", 5'b00000, 2'b00, 1'b0, 16'h1234, 16'h0, 16'h0, 16'h0FFF, 3'b100);
        run_op("halt", 5'b11111, 2'b00, 1'b0, 16'h1234, 16'h0, 16'h0, 16'h0FFF, 3'b100);
        run_op("mov", 5'b01011, 2'b00, 1'b0, 16'h1357, 16'h0, 16'h0, 16'h1357, 3'b100);
        run_op("br", 5'b10011, 2'b00, 1'b0, 16'h1357, 16'h0, 16'h0ABC, 16'h0ABC, 3'b100);
        run_op("ld", 5'b01101, 2'b00, 1'b0, 16'h1000, 16'h0, 16'hFFFC, 16'h0FFC, 3'b100);
        run_op("undef", 5'b00110, 2'b10, 1'b0, 16'h0000, 16'h0000, 16'h0, 16'h0FFF, 3'b100);

        // in_valid low: flags must not move even for a flag-writing opcode
        drive(5'b00110, 2'b00, 1'b0, 16'h0001, 16'h0001, 16'h0);
        in_valid = 1'b0;
        step();
        chk("novalid.flags", 32'(flags), 32'b100);

`ifdef EXEC_MUL_EN
        begin
            int stall_cnt;
            int done_cyc;
            // 3 * -2 = -6
            drive(5'b00010, 2'b00, 1'b0, 16'h0003, 16'hFFFE, 16'h0);
            @(negedge clk);
            chk("mul.issue_stall", 32'(stall), 32'h1);
            chk("mul.issue_out", 32'(alu_out), 32'h0FFF);
            stall_cnt = 1;
            done_cyc  = -1;
            for (int cyc = 1; cyc <= 40; cyc++) begin
                step();
                in_valid = 1'b0;
                read_data_1 = 16'hDEAD;
                read_data_2 = 16'hBEEF;
                @(negedge clk);
                if (mul_done) begin
                    done_cyc = cyc;
                    chk("mul.done_out", 32'(alu_out), 32'hFFFA);
                    chk("mul.done_stall", 32'(stall), 32'h0);
                    break;
                end
                if (stall) stall_cnt++;
            end
            chk("mul.stall_cycles", 32'(stall_cnt), 32'd17);
            chk("mul.done_cycle", 32'(done_cyc), 32'd17);
            step();
            chk("mul.flags", 32'(flags), 32'b001);
            chk("mul.done_pulse", 32'(mul_done), 32'h0);

            // 0x100 * 0x100 = 0x10000: low half zero, upper half not sign-consistent
            drive(5'b00010, 2'b00, 1'b1, 16'h0100, 16'h0, 16'h0100);
            step();
            in_valid = 1'b0;
            for (int cyc = 1; cyc <= 40 && !mul_done; cyc++) step();
            chk("mul2.done", 32'(mul_done), 32'h1);
            chk("mul2.out", 32'(alu_out), 32'h0000);
            step();
            chk("mul2.flags", 32'(flags), 32'b110);

            // Reset mid-multiply
            drive(5'b00010, 2'b00, 1'b0, 16'h0007, 16'h0009, 16'h0);
            step();
            in_valid = 1'b0;
            repeat (4) step();
            @(negedge clk);
            chk("mulrst.pre_stall", 32'(stall), 32'h1);
            rst_n = 1'b0;
            #1;
            chk("mulrst.stall", 32'(stall), 32'h0);
            chk("mulrst.flags", 32'(flags), 32'h0);
            chk("mulrst.done", 32'(mul_done), 32'h0);
            step();
            rst_n = 1'b1;
            run_op("mulrst.add", 5'b00110, 2'b00, 1'b0, 16'h8000, 16'h8000, 16'h0, 16'h0000, 3'b110);
            chk("mulrst.add_stall", 32'(stall), 32'h0);
        end
`else
        begin
            int stall_seen;
            stall_seen = 0;
            drive(5'b00010, 2'b00, 1'b0, 16'h0003, 16'hFFFE, 16'h0);
            for (int cyc = 0; cyc < 4; cyc++) begin
                @(negedge clk);
                if (stall || mul_done) stall_seen++;
                if (cyc == 0) chk("mul_off.out", 32'(alu_out), 32'h0FFF);
                step();
            end
            chk("mul_off.stall", 32'(stall_seen), 32'd0);
            chk("mul_off.flags", 32'(flags), 32'b100);
            in_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("rstpulse.flags", 32'(flags), 32'h0);
            step();
            rst_n = 1'b1;
            run_op("rstpulse.add", 5'b00110, 2'b00, 1'b0, 16'h8000, 16'h8000, 16'h0, 16'h0000, 3'b110);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
